// File: rtl/score_sram_arbiter.sv
// Two-port (score writer / normaliser reader) arbiter for the byte-wide SRAM; words go out as lo then hi byte.
// Optional SRAM_WR_VERIFY_EN: read back every written word and flag mismatches on the sticky verify_err.
module score_sram_arbiter #(
    parameter int          IDX_W       = 8,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [20:0] BASE_ADDR   = 21'h000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_req,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [15:0]      wr_data,
    output logic             wr_ack,
    input  logic             rd_req,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [15:0]      rd_data,
    output logic             rd_ack,
    output logic             busy,
`ifdef SRAM_WR_VERIFY_EN
    output logic             verify_err,
`endif
    inout  wire  [7:0]       sram_data,
    output logic [20:0]      sram_addr,
    output logic             sram_ce,
    output logic             sram_we,
    output logic             sram_oe
);

    typedef enum logic [2:0] {IDLE, W_SETUP, W_STROBE, W_HOLD, R_STROBE, DONE} state_t;

    localparam logic [3:0] W_LAST = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] R_LAST = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic        hi_q, hi_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [20:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        last_rd_q, last_rd_d;
    logic        wr_ack_q, wr_ack_d;
    logic        rd_ack_q, rd_ack_d;
    logic [7:0]  rd_lo_q, rd_lo_d;
    logic [15:0] rd_data_q, rd_data_d;
`ifdef SRAM_WR_VERIFY_EN
    logic        is_wr_q, is_wr_d;
    logic        err_q, err_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            hi_q      <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            last_rd_q <= 1'b1;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_lo_q   <= '0;
            rd_data_q <= '0;
`ifdef SRAM_WR_VERIFY_EN
            is_wr_q   <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            last_rd_q <= last_rd_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
            rd_lo_q   <= rd_lo_d;
            rd_data_q <= rd_data_d;
`ifdef SRAM_WR_VERIFY_EN
            is_wr_q   <= is_wr_d;
            err_q     <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        last_rd_d = last_rd_q;
        wr_ack_d  = 1'b0;
        rd_ack_d  = 1'b0;
        rd_lo_d   = rd_lo_q;
        rd_data_d = rd_data_q;
`ifdef SRAM_WR_VERIFY_EN
        is_wr_d   = is_wr_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                // On a tie the port that did not win last time gets the bus.
                if (wr_req && (!rd_req || last_rd_q)) begin
                    last_rd_d = 1'b0;
                    data_d    = wr_data;
                    addr_d    = BASE_ADDR + (21'(wr_idx) << 1);
                    hi_d      = 1'b0;
                    cnt_d     = '0;
                    state_d   = W_SETUP;
`ifdef SRAM_WR_VERIFY_EN
                    is_wr_d   = 1'b1;
`endif
                end else if (rd_req) begin
                    last_rd_d = 1'b1;
                    addr_d    = BASE_ADDR + (21'(rd_idx) << 1);
                    hi_d      = 1'b0;
                    cnt_d     = '0;
                    state_d   = R_STROBE;
`ifdef SRAM_WR_VERIFY_EN
                    is_wr_d   = 1'b0;
`endif
                end
            end
            W_SETUP: begin
                cnt_d   = '0;
                state_d = W_STROBE;
            end
            W_STROBE: begin
                if (cnt_q == W_LAST) state_d = W_HOLD;
                else                 cnt_d   = cnt_q + 4'd1;
            end
            W_HOLD: begin
                if (!hi_q) begin
                    hi_d    = 1'b1;
                    addr_d  = addr_q + 21'd1;
                    state_d = W_SETUP;
                end else begin
`ifdef SRAM_WR_VERIFY_EN
                    hi_d    = 1'b0;
                    addr_d  = addr_q - 21'd1;
                    cnt_d   = '0;
                    state_d = R_STROBE;
`else
                    wr_ack_d = 1'b1;
                    state_d  = DONE;
`endif
                end
            end
            R_STROBE: begin
                if (cnt_q == R_LAST) begin
                    cnt_d = '0;
                    if (!hi_q) begin
                        rd_lo_d = sram_data;
                        hi_d    = 1'b1;
                        addr_d  = addr_q + 21'd1;
                    end else begin
                        state_d = DONE;
`ifdef SRAM_WR_VERIFY_EN
                        if (is_wr_q) begin
                            if ({sram_data, rd_lo_q} != data_q) err_d = 1'b1;
                            wr_ack_d = 1'b1;
                        end else begin
                            rd_data_d = {sram_data, rd_lo_q};
                            rd_ack_d  = 1'b1;
                        end
`else
                        rd_data_d = {sram_data, rd_lo_q};
                        rd_ack_d  = 1'b1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from the state flop so a reset releases the bus without waiting for a clock.
    assign sram_ce   = !(state_q inside {W_SETUP, W_STROBE, W_HOLD, R_STROBE});
    assign sram_we   = (state_q != W_STROBE);
    assign sram_oe   = (state_q != R_STROBE);
    assign sram_data = (state_q inside {W_SETUP, W_STROBE, W_HOLD}) ?
                       (hi_q ? data_q[15:8] : data_q[7:0]) : 8'hzz;
    assign sram_addr = addr_q;
    assign busy      = (state_q != IDLE);
    assign wr_ack    = wr_ack_q;
    assign rd_ack    = rd_ack_q;
    assign rd_data   = rd_data_q;
`ifdef SRAM_WR_VERIFY_EN
    assign verify_err = err_q;
`endif

endmodule

// File: tb/tb_score_sram_arbiter.sv
// Directed bench for score_sram_arbiter: two instances (base 0 and a wrapping base) each with a small SRAM model.
module tb_score_sram_arbiter;

`ifdef SRAM_WR_VERIFY_EN
    localparam int WR_LAT = 11;
`else
    localparam int WR_LAT = 7;
`endif
    localparam int RD_LAT = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_req, rd_req;
    logic [7:0]  wr_idx, rd_idx;
    logic [15:0] wr_data;
    logic        wr_ack, rd_ack, busy;
    logic [15:0] rd_data;
    wire  [7:0]  sram_data;
    logic [20:0] sram_addr;
    logic        sram_ce, sram_we, sram_oe;
    logic        verify_err;

    logic        w_wr_req;
    logic [7:0]  w_wr_idx;
    logic [15:0] w_wr_data;
    logic        w_rd_req = 1'b0;
    logic [7:0]  w_rd_idx = 8'd0;
    logic        w_wr_ack, w_rd_ack, w_busy;
    logic [15:0] w_rd_data;
    wire  [7:0]  w_sram_data;
    logic [20:0] w_sram_addr;
    logic        w_sram_ce, w_sram_we, w_sram_oe;
    logic        w_verify_err;

    logic [7:0]  mem  [16];
    logic [7:0]  memw [16];
    logic        corrupt_hi;
    logic [20:0] last_wr_addr, w_last_wr_addr;
    int          we_low_cnt = 0;
    int          both_low_cnt = 0;
    int          check_count = 0;
    int          error_count = 0;

    always #10 clk = ~clk;

    score_sram_arbiter #(.IDX_W(8), .WAIT_CYCLES(1), .BASE_ADDR(21'h000000)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_idx(wr_idx), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_data(rd_data), .rd_ack(rd_ack),
        .busy(busy),
`ifdef SRAM_WR_VERIFY_EN
        .verify_err(verify_err),
`endif
        .sram_data(sram_data), .sram_addr(sram_addr),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_oe(sram_oe)
    );

    score_sram_arbiter #(.IDX_W(8), .WAIT_CYCLES(1), .BASE_ADDR(21'h1FFFFE)) dutw (
        .clk(clk), .reset(reset),
        .wr_req(w_wr_req), .wr_idx(w_wr_idx), .wr_data(w_wr_data), .wr_ack(w_wr_ack),
        .rd_req(w_rd_req), .rd_idx(w_rd_idx), .rd_data(w_rd_data), .rd_ack(w_rd_ack),
        .busy(w_busy),
`ifdef SRAM_WR_VERIFY_EN
        .verify_err(w_verify_err),
`endif
        .sram_data(w_sram_data), .sram_addr(w_sram_addr),
        .sram_ce(w_sram_ce), .sram_we(w_sram_we), .sram_oe(w_sram_oe)
    );

`ifndef SRAM_WR_VERIFY_EN
    assign verify_err   = 1'b0;
    assign w_verify_err = 1'b0;
`endif

    // A floating bus reads as FF so a released bus is distinguishable from a driven data byte.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pu
        pullup (sram_data[gi]);
        pullup (w_sram_data[gi]);
    end

    // SRAM models: latch writes while WE is low, drive reads while OE is low.
    always @(posedge clk) begin
        if (!sram_ce && !sram_we) begin
            mem[sram_addr[3:0]] <= (corrupt_hi && sram_addr[0]) ? (sram_data ^ 8'h10) : sram_data;
            last_wr_addr        <= sram_addr;
        end
        if (!w_sram_ce && !w_sram_we) begin
            memw[w_sram_addr[3:0]] <= w_sram_data;
            w_last_wr_addr         <= w_sram_addr;
        end
    end
    assign sram_data   = (!sram_ce && !sram_oe) ? mem[sram_addr[3:0]] : 8'hzz;
    assign w_sram_data = (!w_sram_ce && !w_sram_oe) ? memw[w_sram_addr[3:0]] : 8'hzz;

    always @(negedge clk) begin
        if (!sram_we) we_low_cnt <= we_low_cnt + 1;
        if ((!sram_we && !sram_oe) || (!w_sram_we && !w_sram_oe)) both_low_cnt <= both_low_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction on the base-0 instance; latency counted from the grant cycle to the ack cycle.
    task automatic applyStimulus(input bit is_wr, input logic [7:0] idx, input logic [15:0] data,
                                 input int exp_lat, input string tag);
        int lat;
        bit got;
        @(negedge clk);
        if (is_wr) begin wr_idx = idx; wr_data = data; wr_req = 1'b1; end
        else       begin rd_idx = idx; rd_req = 1'b1; end
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (is_wr ? wr_ack : rd_ack) got = 1;
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        checkOutput(tag, lat, exp_lat);
    endtask

    initial begin
        logic [3:0] seq;
        logic [15:0] rd_vals [2];
        int n_ack, n_rd, we0, lat, acks;
        bit got;

        reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_idx = '0; rd_idx = '0; wr_data = '0;
        w_wr_req = 1'b0; w_wr_idx = '0; w_wr_data = '0; corrupt_hi = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_strobes", {29'd0, sram_ce, sram_we, sram_oe}, 32'd7);
        checkOutput("rst_addr", {11'd0, sram_addr}, 32'd0);
        checkOutput("rst_acks_busy", {29'd0, wr_ack, rd_ack, busy}, 32'd0);
        checkOutput("rst_rd_data", {16'd0, rd_data}, 32'd0);
        checkOutput("rst_bus_z", {24'd0, sram_data}, 32'hFF);
        reset = 1'b1;

        we0 = we_low_cnt;
        applyStimulus(1'b1, 8'd3, 16'h00C1, WR_LAT, "wr_latency");
        checkOutput("wr_lo_byte", {24'd0, mem[6]}, 32'hC1);
        checkOutput("wr_hi_byte", {24'd0, mem[7]}, 32'h00);
        checkOutput("wr_last_addr", {11'd0, last_wr_addr}, 32'd7);
        checkOutput("wr_we_cycles", we_low_cnt - we0, 32'd2);

        applyStimulus(1'b0, 8'd3, 16'h0000, RD_LAT, "rd_latency");
        checkOutput("rd_data", {16'd0, rd_data}, 32'h00C1);

        // Both ports held high: last grant was the read, so the writer goes first.
        @(negedge clk);
        wr_idx = 8'd5; wr_data = 16'h1234; rd_idx = 8'd5;
        wr_req = 1'b1; rd_req = 1'b1;
        seq = '0; n_ack = 0; n_rd = 0;
        rd_vals[0] = '0; rd_vals[1] = '0;
        for (int c = 0; c < 200 && n_ack < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (wr_ack) begin seq = {seq[2:0], 1'b1}; n_ack++; wr_data = 16'hBEEF; end
            if (rd_ack) begin
                seq = {seq[2:0], 1'b0}; n_ack++;
                if (n_rd < 2) rd_vals[n_rd] = rd_data;
                n_rd++;
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        checkOutput("fair_ack_count", n_ack, 32'd4);
        checkOutput("fair_order", {28'd0, seq}, 32'hA);
        checkOutput("fair_rd0", {16'd0, rd_vals[0]}, 32'h1234);
        checkOutput("fair_rd1", {16'd0, rd_vals[1]}, 32'hBEEF);
        @(negedge clk);

        // Reset arrives while WE is low on the first byte.
        wr_idx = 8'd4; wr_data = 16'h5A3C; wr_req = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (!sram_we) got = 1;
        end
        checkOutput("mid_reach_strobe", {31'd0, got}, 32'd1);
        #3 reset = 1'b0;
        #1;
        checkOutput("mid_rst_strobes", {29'd0, sram_ce, sram_we, sram_oe}, 32'd7);
        checkOutput("mid_rst_bus_z", {24'd0, sram_data}, 32'hFF);
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        wr_req = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (wr_ack) acks++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (wr_ack) acks++;
        end
        checkOutput("mid_no_ack", acks, 32'd0);
        checkOutput("mid_busy_after", {31'd0, busy}, 32'd0);
        applyStimulus(1'b1, 8'd4, 16'h5A3C, WR_LAT, "mid_rewrite_lat");
        checkOutput("mid_rewrite_lo", {24'd0, mem[8]}, 32'h3C);
        checkOutput("mid_rewrite_hi", {24'd0, mem[9]}, 32'h5A);

        // Base 1FFFFE + 2*1 wraps to byte addresses 0 and 1.
        @(negedge clk);
        w_wr_idx = 8'd1; w_wr_data = 16'hA55A; w_wr_req = 1'b1;
        lat = 0; got = 0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (w_wr_ack) got = 1;
        end
        w_wr_req = 1'b0;
        checkOutput("wrap_latency", lat, WR_LAT);
        checkOutput("wrap_lo_byte", {24'd0, memw[0]}, 32'h5A);
        checkOutput("wrap_hi_byte", {24'd0, memw[1]}, 32'hA5);
        checkOutput("wrap_last_addr", {11'd0, w_last_wr_addr}, 32'd1);

`ifdef SRAM_WR_VERIFY_EN
        checkOutput("verify_clean", {31'd0, verify_err}, 32'd0);
        corrupt_hi = 1'b1;
        applyStimulus(1'b1, 8'd2, 16'hF6A5, WR_LAT, "verify_bad_lat");
        corrupt_hi = 1'b0;
        checkOutput("verify_err_set", {31'd0, verify_err}, 32'd1);
        applyStimulus(1'b1, 8'd2, 16'h0102, WR_LAT, "verify_good_lat");
        checkOutput("verify_err_sticky", {31'd0, verify_err}, 32'd1);
        checkOutput("verify_w_clean", {31'd0, w_verify_err}, 32'd0);
`endif

        checkOutput("oe_we_overlap", both_low_cnt, 32'd0);
        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/score_sram_arbiter.md
Name: score_sram_arbiter

Overview:
- Arbitrates the shared byte-wide onboard SRAM between two 16-bit `num` requesters.
- Write port: GDP score path, which stores `senone_score` at the senone index.
- Read port: normaliser, which fetches stored scores.
- Splits each word into two sequenced byte accesses and generates all SRAM strobes.
- Owns the `sram_data` tristate.

Parameters:
- IDX_W, 8, width of word index (senone index).
- WAIT_CYCLES, 1, cycles a strobe (WE or OE) is held low per byte; legal range 1..15.
- BASE_ADDR, 21'h000000, SRAM byte address of word index 0.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset
- wr_req  in  1  write request; hold high with wr_idx and wr_data stable until wr_ack
- wr_idx  in  IDX_W  word index to write
- wr_data  in  16  signed num to store
- wr_ack  out  1  one-cycle pulse: write complete
- rd_req  in  1  read request; hold high with rd_idx stable until rd_ack
- rd_idx  in  IDX_W  word index to read
- rd_data  out  16  read result; valid in the rd_ack cycle and held until the next read completes
- rd_ack  out  1  one-cycle pulse: rd_data valid
- busy  out  1  high whenever state is not IDLE
- sram_data  inout  8  SRAM data bus
- sram_addr  out  21  SRAM byte address
- sram_ce, sram_we, sram_oe  out  1 each  active-low SRAM strobes

Behaviour:
- **Clock and reset:** one clock, clk. reset is asynchronous and active-low.
- **Reset values:**
  - sram_ce = sram_we = sram_oe = 1; sram_addr = 0; sram_data = Z.
  - wr_ack = rd_ack = 0; rd_data = 0; busy = 0.
  - last_grant = READ, so the writer wins the first tie.
- **Reset mid-transaction:** strobes deassert immediately (asynchronously), the bus tristates, and the transaction is dropped with no ack.
- **Addressing:**
  - Low byte at BASE_ADDR + 2*idx; high byte at that address + 1.
  - Sums are modulo 2^21 (wrap, no error).
- **States:** IDLE, W_SETUP, W_STROBE, W_HOLD, R_STROBE, DONE; a byte counter selects lo/hi.
- **IDLE:**
  - Samples wr_req and rd_req.
  - Exactly one asserted: grant it.
  - Both asserted: grant the port that is not last_grant.
  - On grant: update last_grant, latch idx/data, and go to W_SETUP or R_STROBE.
- **Write, per byte:**
  - W_SETUP (1 cycle): ce=0, we=1, address and byte driven on sram_data.
  - W_STROBE (WAIT_CYCLES cycles): we=0.
  - W_HOLD (1 cycle): we=1, data still driven.
  - Do the lo byte, then the hi byte, then go to DONE.
- **Read, per byte:**
  - R_STROBE (WAIT_CYCLES+1 cycles): ce=0, oe=0, bus Z.
  - Sample sram_data into the lo/hi byte on the final cycle.
  - After the hi byte, go to DONE.
- **DONE (1 cycle):**
  - Strobes high, bus Z.
  - Pulse wr_ack or rd_ack for the granted port (registered).
  - Return to IDLE.
- **Latency, IDLE-grant cycle to ack cycle:**
  - Write: 2*(WAIT_CYCLES+2)+1 = 7 cycles at the default.
  - Read: 2*(WAIT_CYCLES+1)+1 = 5 cycles at the default.
- **Requester handshake:**
  - Requesters drop req on the clock edge after seeing ack; a registered requester therefore presents req low in the following IDLE cycle.
  - A req still high in that IDLE cycle is a new request and is serviced.
- **Bus safety:**
  - sram_data is driven only in W_* states.
  - oe and we are never simultaneously 0.
  - ce is high in IDLE and DONE.
- **Changes while busy:** request or data changes on the ungranted port are ignored until IDLE.

Optional Feature:
- Macro: SRAM_WR_VERIFY_EN.
- **Defined:**
  - After W_HOLD of the hi byte, the block reads back both bytes using the R_STROBE timing (adds 2*(WAIT_CYCLES+1) cycles before DONE).
  - Compares the readback against the latched wr_data.
  - A mismatch sets output verify_err (1 bit, sticky, cleared only by reset). wr_ack is still issued.
- **Undefined:** no readback, no verify_err port, write latency as stated above.

Test Plan:
1. **Single write.** BASE=0, wr_req with idx=3, data=16'h00C1 → addr 6 byte C1 with we low 1 cycle, then addr 7 byte 00; wr_ack 7 cycles after grant.
2. **Single read.** SRAM model bytes [6]=C1, [7]=00; rd_req idx=3 → rd_ack 5 cycles after grant with rd_data=16'h00C1; oe and we never both low.
3. **Fairness.** After reset, wr_req and rd_req are both held continuously → grant order W, R, W, R; rd_data and stored values correct.
4. **Reset mid-write.** reset low during W_STROBE → ce/we/oe=1 and sram_data Z in the same cycle; no wr_ack; after release, busy=0 and a new write completes normally.
5. **Address wrap.** BASE=21'h1FFFFE, write idx=1 → byte addresses 21'h000000 and 21'h000001.
6. **Verify (SRAM_WR_VERIFY_EN defined).** SRAM model corrupts the hi byte of the write 16'hF6A5 → verify_err=1, still set after the next clean write; wr_ack still issued.
